// File: rtl/adpll_pkg.sv
// rtl/adpll_pkg.sv - shared types, default constants and saturating add for the ADPLL
package adpll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INTEG,
        ST_SUM
    } state_t;

    localparam int DEF_DELAY_W  = 12;
    localparam int DEF_CTRL_W   = 10;
    localparam int DEF_ACC_W    = 20;
    localparam int DEF_KP_SH    = 2;
    localparam int DEF_KI_SH    = 3;
    localparam int DEF_CENTER   = 512;
    localparam int DEF_LOCK_TOL = 2;
    localparam int DEF_LOCK_CNT = 16;

    // Operands arrive sign-extended to 64 bits; result is clamped to a w-bit signed range.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        return s;
    endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// rtl/adpll_lock_detect.sv - consecutive in-tolerance sample counter and lock flag
module adpll_lock_detect
    import adpll_pkg::*;
#(
    parameter int ERR_W    = DEF_DELAY_W,
    parameter int LOCK_TOL = DEF_LOCK_TOL,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ERR_W-1:0] err_mag,
    input  logic             update,
    output logic             locked
);

    localparam int CNT_W = $clog2(LOCK_CNT + 1);

    logic [CNT_W-1:0] cnt;

    // locked follows the counter one cycle late so it moves with the output strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            locked <= 1'b0;
        end else begin
            if (update) begin
                if (err_mag <= ERR_W'(LOCK_TOL)) begin
                    if (cnt != CNT_W'(LOCK_CNT))
                        cnt <= cnt + 1'b1;
                end else begin
                    cnt <= '0;
                end
            end
            locked <= (cnt == CNT_W'(LOCK_CNT));
        end
    end

endmodule

// File: rtl/adpll_loop_filter.sv
// rtl/adpll_loop_filter.sv - PI loop filter turning TDC samples into a clamped DCO control word
module adpll_loop_filter
    import adpll_pkg::*;
#(
    parameter int DELAY_W  = DEF_DELAY_W,
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int KP_SH    = DEF_KP_SH,
    parameter int KI_SH    = DEF_KI_SH,
    parameter int CENTER   = DEF_CENTER,
    parameter int LOCK_TOL = DEF_LOCK_TOL,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DELAY_W-1:0] tdc_delay,
    input  logic               tdc_lead,
    input  logic               tdc_done,
    input  logic               freeze,
    output logic [CTRL_W-1:0]  dco_ctrl,
    output logic               ctrl_valid,
    output logic               locked,
    output logic               sample_dropped
);

    localparam int SW = ACC_W + 2;
    localparam logic signed [SW-1:0] SUM_MAX = SW'((1 << CTRL_W) - 1);

    state_t                    state;
    logic                      done_q;
    logic                      new_sample;
    logic signed [DELAY_W:0]   err_in;
    logic signed [DELAY_W:0]   err_q;
    logic signed [DELAY_W:0]   err_shr;
    logic signed [DELAY_W:0]   err_abs;
    logic signed [ACC_W-1:0]   integ;
    logic signed [ACC_W-1:0]   integ_next;
    logic signed [63:0]        integ_sum64;
    logic signed [SW-1:0]      err_ext;
    logic signed [SW-1:0]      integ_ext;
    logic signed [SW-1:0]      sum;
    logic [CTRL_W-1:0]         ctrl_clamped;

    assign new_sample = tdc_done & ~done_q;

    always_comb begin
        err_in      = tdc_lead ? $signed({1'b0, tdc_delay}) : -$signed({1'b0, tdc_delay});
        err_shr     = err_q >>> KI_SH;
        integ_sum64 = sat_add({{(64 - ACC_W){integ[ACC_W-1]}}, integ},
                              {{(64 - DELAY_W - 1){err_shr[DELAY_W]}}, err_shr}, ACC_W);
        integ_next  = integ_sum64[ACC_W-1:0];
        err_abs     = err_q[DELAY_W] ? -err_q : err_q;

        // SUM sees the integrator already updated by the preceding INTEG cycle.
        err_ext   = {{(SW - DELAY_W - 1){err_q[DELAY_W]}}, err_q};
        integ_ext = {{(SW - ACC_W){integ[ACC_W-1]}}, integ};
        sum       = SW'(CENTER) + (err_ext <<< KP_SH) + integ_ext;

        if (sum[SW-1])
            ctrl_clamped = '0;
        else if (sum > SUM_MAX)
            ctrl_clamped = '1;
        else
            ctrl_clamped = sum[CTRL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            done_q         <= 1'b0;
            err_q          <= '0;
            integ          <= '0;
            dco_ctrl       <= CTRL_W'(CENTER);
            ctrl_valid     <= 1'b0;
            sample_dropped <= 1'b0;
        end else begin
            done_q         <= tdc_done;
            ctrl_valid     <= 1'b0;
            sample_dropped <= new_sample && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (new_sample) begin
                        err_q <= err_in;
                        state <= ST_INTEG;
                    end
                end
                ST_INTEG: begin
                    if (!freeze)
                        integ <= integ_next;
                    state <= ST_SUM;
                end
                ST_SUM: begin
                    dco_ctrl   <= ctrl_clamped;
                    ctrl_valid <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    adpll_lock_detect #(
        .ERR_W    (DELAY_W),
        .LOCK_TOL (LOCK_TOL),
        .LOCK_CNT (LOCK_CNT)
    ) u_lock (
        .clk     (clk),
        .reset   (reset),
        .err_mag (err_abs[DELAY_W-1:0]),
        .update  (state == ST_INTEG),
        .locked  (locked)
    );

endmodule

// File: tb/tb_adpll_loop_filter.sv
// tb/tb_adpll_loop_filter.sv - directed self-checking bench for adpll_loop_filter
module tb_adpll_loop_filter;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] tdc_delay;
    logic        tdc_lead;
    logic        tdc_done;
    logic        freeze;
    logic [9:0]  dco_ctrl;
    logic        ctrl_valid;
    logic        locked;
    logic        sample_dropped;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adpll_loop_filter dut (
        .clk            (clk),
        .reset          (reset),
        .tdc_delay      (tdc_delay),
        .tdc_lead       (tdc_lead),
        .tdc_done       (tdc_done),
        .freeze         (freeze),
        .dco_ctrl       (dco_ctrl),
        .ctrl_valid     (ctrl_valid),
        .locked         (locked),
        .sample_dropped (sample_dropped)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; tdc_done = 1'b0; freeze = 1'b0; tdc_delay = '0; tdc_lead = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one sample; captures ctrl_valid after each of the three following edges.
    task automatic run_sample(input logic [11:0] d, input logic l, input logic fz,
                              output logic [2:0] vseq);
        @(negedge clk);
        tdc_delay = d; tdc_lead = l; freeze = fz; tdc_done = 1'b1;
        @(posedge clk); #1 vseq[0] = ctrl_valid;
        @(negedge clk);
        tdc_done = 1'b0; tdc_delay = 12'($urandom); tdc_lead = 1'($urandom);
        @(posedge clk); #1 vseq[1] = ctrl_valid;
        @(posedge clk); #1 vseq[2] = ctrl_valid;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (dco_ctrl !== 10'd512) begin n_err++; $display("FAIL reset_dco got %0d want 512", dco_ctrl); end
        n_cmp++; if (ctrl_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", ctrl_valid); end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %b want 0", locked); end
        n_cmp++; if (sample_dropped !== 1'b0) begin n_err++; $display("FAIL reset_dropped got %b want 0", sample_dropped); end
        // tdc_done already high as reset releases counts as an edge
        @(negedge clk);
        reset = 1'b1; tdc_done = 1'b1; tdc_delay = 12'd8; tdc_lead = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk);
        @(negedge clk); tdc_done = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        n_cmp++; if (ctrl_valid !== 1'b1) begin n_err++; $display("FAIL first_cycle_edge_valid got %b want 1", ctrl_valid); end
        n_cmp++; if (dco_ctrl !== 10'd545) begin n_err++; $display("FAIL first_cycle_edge_dco got %0d want 545", dco_ctrl); end
    endtask

    task automatic test_basic();
        logic [2:0] v;
        do_reset();
        run_sample(12'd8, 1'b1, 1'b0, v);
        n_cmp++; if (v !== 3'b100) begin n_err++; $display("FAIL lead_latency got %b want 100", v); end
        n_cmp++; if (dco_ctrl !== 10'd545) begin n_err++; $display("FAIL lead_dco got %0d want 545", dco_ctrl); end
        n_cmp++; if (dut.integ !== 20'sd1) begin n_err++; $display("FAIL lead_integ got %0d want 1", dut.integ); end
        do_reset();
        run_sample(12'd8, 1'b0, 1'b0, v);
        n_cmp++; if (v !== 3'b100) begin n_err++; $display("FAIL lag_latency got %b want 100", v); end
        n_cmp++; if (dco_ctrl !== 10'd479) begin n_err++; $display("FAIL lag_dco got %0d want 479", dco_ctrl); end
        n_cmp++; if (dut.integ !== -20'sd1) begin n_err++; $display("FAIL lag_integ got %0d want -1", dut.integ); end
        @(posedge clk); #1;
        n_cmp++; if (dco_ctrl !== 10'd479 || ctrl_valid !== 1'b0) begin n_err++; $display("FAIL hold_dco got %0d/%b want 479/0", dco_ctrl, ctrl_valid); end
    endtask

    task automatic test_clamp();
        logic [2:0] v;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_sample(12'd4095, 1'b1, 1'b0, v);
            n_cmp++; if (dco_ctrl !== 10'd1023) begin n_err++; $display("FAIL clamp_hi[%0d] got %0d want 1023", i, dco_ctrl); end
        end
        do_reset();
        for (int i = 0; i < 2; i++) begin
            run_sample(12'd4095, 1'b0, 1'b0, v);
            n_cmp++; if (dco_ctrl !== 10'd0) begin n_err++; $display("FAIL clamp_lo[%0d] got %0d want 0", i, dco_ctrl); end
        end
        n_cmp++; if (dut.integ !== -20'sd1024) begin n_err++; $display("FAIL lag_floor_integ got %0d want -1024", dut.integ); end
    endtask

    task automatic test_integ_sat();
        logic [2:0] v;
        do_reset();
        for (int i = 0; i < 1026; i++) run_sample(12'd4095, 1'b1, 1'b0, v);
        n_cmp++; if (dut.integ !== 20'sd524286) begin n_err++; $display("FAIL integ_pre_sat got %0d want 524286", dut.integ); end
        for (int i = 0; i < 4; i++) run_sample(12'd4095, 1'b1, 1'b0, v);
        n_cmp++; if (dut.integ !== 20'sd524287) begin n_err++; $display("FAIL integ_sat got %0d want 524287", dut.integ); end
        n_cmp++; if (dco_ctrl !== 10'd1023) begin n_err++; $display("FAIL integ_sat_dco got %0d want 1023", dco_ctrl); end
    endtask

    task automatic test_lock();
        logic [2:0] v;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            run_sample(12'd2, 1'b1, 1'b0, v);
            n_cmp++; if (locked !== (i == 16)) begin n_err++; $display("FAIL lock_rise[%0d] got %b want %b", i, locked, (i == 16)); end
        end
        n_cmp++; if (dco_ctrl !== 10'd520) begin n_err++; $display("FAIL lock_dco got %0d want 520", dco_ctrl); end
        run_sample(12'd2, 1'b0, 1'b0, v);
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_hold got %b want 1", locked); end
        run_sample(12'd5, 1'b1, 1'b0, v);
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL lock_drop got %b want 0", locked); end
        run_sample(12'd1, 1'b1, 1'b0, v);
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL lock_restart got %b want 0", locked); end
    endtask

    task automatic test_back_to_back();
        int nvalid;
        int ndrop;
        do_reset();
        nvalid = 0; ndrop = 0;
        @(negedge clk); tdc_done = 1'b1; tdc_delay = 12'd8; tdc_lead = 1'b1;
        @(posedge clk); #1 nvalid += int'(ctrl_valid); ndrop += int'(sample_dropped);
        @(negedge clk); tdc_done = 1'b0;
        @(posedge clk); #1 nvalid += int'(ctrl_valid); ndrop += int'(sample_dropped);
        @(negedge clk); tdc_done = 1'b1; tdc_delay = 12'd4095; tdc_lead = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (sample_dropped !== 1'b1) begin n_err++; $display("FAIL drop_pulse got %b want 1", sample_dropped); end
        nvalid += int'(ctrl_valid); ndrop += int'(sample_dropped);
        @(negedge clk); tdc_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 nvalid += int'(ctrl_valid); ndrop += int'(sample_dropped);
        end
        n_cmp++; if (nvalid != 1) begin n_err++; $display("FAIL drop_valid_count got %0d want 1", nvalid); end
        n_cmp++; if (ndrop != 1) begin n_err++; $display("FAIL drop_pulse_count got %0d want 1", ndrop); end
        n_cmp++; if (dco_ctrl !== 10'd545) begin n_err++; $display("FAIL drop_dco got %0d want 545", dco_ctrl); end
    endtask

    task automatic test_freeze();
        logic [2:0] v;
        do_reset();
        run_sample(12'd8, 1'b1, 1'b0, v);
        run_sample(12'd16, 1'b1, 1'b1, v);
        n_cmp++; if (dut.integ !== 20'sd1) begin n_err++; $display("FAIL freeze_integ got %0d want 1", dut.integ); end
        n_cmp++; if (dco_ctrl !== 10'd577 || v !== 3'b100) begin n_err++; $display("FAIL freeze_dco got %0d/%b want 577/100", dco_ctrl, v); end
        run_sample(12'd16, 1'b1, 1'b0, v);
        n_cmp++; if (dco_ctrl !== 10'd579) begin n_err++; $display("FAIL unfreeze_dco got %0d want 579", dco_ctrl); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] v;
        int nvalid;
        do_reset();
        for (int i = 0; i < 16; i++) run_sample(12'd1, 1'b1, 1'b0, v);
        n_cmp++; if (locked !== 1'b1 || dco_ctrl !== 10'd516) begin n_err++; $display("FAIL pre_reset got %b/%0d want 1/516", locked, dco_ctrl); end
        @(negedge clk); tdc_done = 1'b1; tdc_delay = 12'd100; tdc_lead = 1'b1;
        @(posedge clk);
        @(negedge clk); tdc_done = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (dco_ctrl !== 10'd512) begin n_err++; $display("FAIL midreset_dco got %0d want 512", dco_ctrl); end
        n_cmp++; if (locked !== 1'b0 || ctrl_valid !== 1'b0 || sample_dropped !== 1'b0) begin
            n_err++; $display("FAIL midreset_flags got %b%b%b want 000", locked, ctrl_valid, sample_dropped); end
        n_cmp++; if (dut.integ !== 20'sd0) begin n_err++; $display("FAIL midreset_integ got %0d want 0", dut.integ); end
        @(negedge clk); reset = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 nvalid += int'(ctrl_valid);
        end
        n_cmp++; if (nvalid != 0 || dco_ctrl !== 10'd512) begin n_err++; $display("FAIL midreset_no_valid got %0d/%0d want 0/512", nvalid, dco_ctrl); end
    endtask

    initial begin
        reset = 1'b1; tdc_done = 1'b0; freeze = 1'b0; tdc_delay = '0; tdc_lead = 1'b0;
        test_reset();
        test_basic();
        test_clamp();
        test_integ_sat();
        test_lock();
        test_back_to_back();
        test_freeze();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
